// File: rtl/charlieplex_seq_pkg.sv
// Shared register map, control-bit positions, FSM encoding and display geometry
// for the charlieplex frame sequencer.
package charlieplex_seq_pkg;

  localparam logic [5:0] ADR_CTRL   = 6'h20;
  localparam logic [5:0] ADR_PERIOD = 6'h21;
  localparam logic [5:0] ADR_STATUS = 6'h22;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_LOOP = 1;
  localparam int CTRL_LAST = 2;

  localparam int N_FRAMES = 4;
  localparam int N_ROWS   = 5;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  function automatic logic row_valid(input logic [2:0] r);
    return r < 3'(N_ROWS);
  endfunction

endpackage

// File: rtl/iWishbone.sv
// Minimal single-beat bus: mPeri is the responding side, mCtrl the issuing side.
// The responder acks one cycle after stb; the issuer holds stb until ack.
interface iWishbone;
  logic       clk;
  logic       rst;
  logic       stb;
  logic       we;
  logic [5:0] adr;
  logic [7:0] dat_c;
  logic [7:0] dat_p;
  logic       ack;

  modport mPeri (input clk, rst, stb, we, adr, dat_c, output dat_p, ack);
  modport mCtrl (input ack, output stb, we, adr, dat_c);
endinterface

// File: rtl/charlieplex_seq_tick.sv
// Restartable divider: tick pulses on the DIV-th cycle after restart drops, then every DIV cycles.
// Held at zero while restart is high, so a new wait always starts a full period.
module charlieplex_seq_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = !restart && (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick) cnt <= '0;
    else                        cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/charlieplex_sequencer.sv
// Plays up to four 5-row frames to a charlieplex display, PERIOD ticks per frame; CPU port acks next cycle.
// Row writes stall on cp.ack. irq_o pulses at sequence end only with CHARLIEPLEX_SEQUENCER_IRQ_EN.
module charlieplex_sequencer
  import charlieplex_seq_pkg::*;
#(
  parameter int nClkHz  = 12000000,
  parameter int nTickHz = 100
) (
  iWishbone.mPeri wb,
  iWishbone.mCtrl cp,
  output logic    irq_o
);
  logic       clk, rst;
  state_t     state;
  logic       en, loop, done, stop, cp_stb, ack_q;
  logic [1:0] last, frame, nf;
  logic [2:0] row;
  logic [7:0] period, ticks_left, cp_dat, rdata, dat_p_q;
  logic [6:0] mem [N_FRAMES][N_ROWS];
  logic       wr, ctrl_wr, stop_wr, tick, wait_end, fin;

  assign clk      = wb.clk;
  assign rst      = wb.rst;
  assign wr       = wb.stb && wb.we;
  assign ctrl_wr  = wr && (wb.adr == ADR_CTRL);
  assign stop_wr  = ctrl_wr && !wb.dat_c[CTRL_EN];
  assign wait_end = (state == S_WAIT) && tick && (ticks_left == 8'd1);
  assign fin      = wait_end && !stop_wr && !(frame < last) && !loop;
  assign nf       = (frame < last) ? frame + 2'd1 : 2'd0;

  charlieplex_seq_tick #(.DIV(nClkHz / nTickHz)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (state != S_WAIT),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (wr && !wb.adr[5] && row_valid(wb.adr[2:0]))
      mem[wb.adr[4:3]][wb.adr[2:0]] <= wb.dat_c[6:0];
  end

  always_comb begin
    rdata = 8'h00;
    if (!wb.adr[5]) begin
      if (row_valid(wb.adr[2:0])) rdata = {1'b0, mem[wb.adr[4:3]][wb.adr[2:0]]};
    end else begin
      case (wb.adr)
        ADR_CTRL:   rdata = {4'b0, last, loop, en};
        ADR_PERIOD: rdata = period;
        ADR_STATUS: rdata = {4'b0, frame, done, state != S_IDLE};
        default:    rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_p_q <= 8'h00;
    end else begin
      ack_q <= wb.stb;
      if (wb.stb) dat_p_q <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      en         <= 1'b0;
      loop       <= 1'b0;
      last       <= 2'd0;
      period     <= 8'd1;
      done       <= 1'b0;
      stop       <= 1'b0;
      frame      <= 2'd0;
      row        <= 3'd0;
      cp_stb     <= 1'b0;
      cp_dat     <= 8'h00;
      ticks_left <= 8'd1;
    end else begin
      // LOOP/LAST always follow CTRL writes; EN only starts from IDLE.
      if (ctrl_wr) begin
        loop <= wb.dat_c[CTRL_LOOP];
        last <= wb.dat_c[CTRL_LAST +: 2];
        if (!wb.dat_c[CTRL_EN]) en <= 1'b0;
      end
      if (wr && wb.adr == ADR_PERIOD) period <= wb.dat_c;

      case (state)
        S_IDLE: begin
          if (ctrl_wr && wb.dat_c[CTRL_EN]) begin
            en     <= 1'b1;
            done   <= 1'b0;
            stop   <= 1'b0;
            frame  <= 2'd0;
            row    <= 3'd0;
            cp_stb <= 1'b1;
            cp_dat <= {1'b0, mem[0][0]};
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (stop_wr) stop <= 1'b1;
          if (!cp_stb) begin
            cp_stb <= 1'b1;
            cp_dat <= {1'b0, mem[frame][row]};
          end else if (cp.ack) begin
            cp_stb <= 1'b0;
            if (row == 3'(N_ROWS - 1)) begin
              row <= 3'd0;
              if (stop || stop_wr) begin
                state <= S_IDLE;
              end else begin
                state      <= S_WAIT;
                ticks_left <= (period == 8'd0) ? 8'd1 : period;
              end
            end else begin
              row <= row + 3'd1;
            end
          end
        end
        S_WAIT: begin
          if (stop_wr) begin
            state <= S_IDLE;
          end else if (fin) begin
            en    <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (wait_end) begin
            frame  <= nf;
            cp_stb <= 1'b1;
            cp_dat <= {1'b0, mem[nf][0]};
            state  <= S_LOAD;
          end else if (tick) begin
            ticks_left <= ticks_left - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_p = dat_p_q;
  assign cp.stb   = cp_stb;
  assign cp.we    = cp_stb;
  assign cp.adr   = {3'b000, row};
  assign cp.dat_c = cp_dat;

`ifdef CHARLIEPLEX_SEQUENCER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= fin;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_charlieplex_sequencer.sv
// Bench for charlieplex_sequencer: register vectors, directed sequences and randomized frame runs
// checked against a frame/timing model; expects irq pulses only when CHARLIEPLEX_SEQUENCER_IRQ_EN is set.
module tb_charlieplex_sequencer;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef CHARLIEPLEX_SEQUENCER_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic irq;

  iWishbone wbi ();
  iWishbone cpi ();
  assign wbi.clk   = clk;
  assign wbi.rst   = rst;
  assign cpi.clk   = clk;
  assign cpi.rst   = rst;
  assign cpi.dat_p = 8'h00;

  charlieplex_sequencer #(.nClkHz(CLK_HZ), .nTickHz(TICK_HZ)) dut (
    .wb    (wbi),
    .cp    (cpi),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  typedef struct { int adr; int dat; int rise; int len; } wr_t;
  typedef struct { bit wr; logic [5:0] adr; logic [7:0] wdat; logic [7:0] exp; } vec_t;

  wr_t      wq[$];
  bit [6:0] mdl_mem [4][5];
  int checks = 0, errors = 0;
  int cyc = 0, hold = 0, dly = 1, rise = 0, irq_cnt = 0, gap_err = 0, slow_row = -1, exp_irq = 0;
  bit rand_ack = 0, prev_hs = 0;

  // Display-side responder and write logger; ack rises dly cycles after stb.
  always @(negedge clk) begin
    cyc++;
    if (irq === 1'b1) irq_cnt++;
    if (cpi.stb === 1'b1) begin
      if (hold == 0) begin
        rise = cyc;
        dly  = rand_ack ? int'($urandom_range(1, 3)) : ((int'(cpi.adr) == slow_row) ? 4 : 1);
      end
      if (prev_hs) gap_err++;
      hold++;
      cpi.ack = (hold == dly + 1);
      prev_hs = cpi.ack;
      if (cpi.ack) begin
        wq.push_back('{int'(cpi.adr), int'(cpi.dat_c), rise, hold});
        hold = 0;
      end
    end else begin
      hold    = 0;
      cpi.ack = 1'b0;
      prev_hs = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    wbi.stb = 1'b1; wbi.we = 1'b1; wbi.adr = a; wbi.dat_c = d;
    @(negedge clk);
    wbi.stb = 1'b0; wbi.we = 1'b0;
    if (a < 6'h20 && a[2:0] < 3'd5) mdl_mem[a[4:3]][a[2:0]] = d[6:0];
  endtask

  task automatic rd_check(input string name, input logic [5:0] a, input logic [7:0] exp);
    @(negedge clk);
    wbi.stb = 1'b1; wbi.we = 1'b0; wbi.adr = a;
    @(negedge clk);
    wbi.stb = 1'b0;
    check({name, "_ack"}, wbi.ack, 1);
    check(name, wbi.dat_p, exp);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int i = 0;
    while (wq.size() < n && i < budget) begin @(negedge clk); i++; end
    check("wait_writes", wq.size() >= n, 1);
  endtask

  task automatic wait_stb_row(input int r, input int budget);
    int i = 0;
    while (!(cpi.stb === 1'b1 && int'(cpi.adr) == r) && i < budget) begin @(negedge clk); i++; end
    check($sformatf("wait_row%0d", r), i < budget, 1);
  endtask

  // Writes k: frame (k/5) mod (last+1), row k mod 5; PERIOD*DIV idle cycles between frames, one between rows.
  task automatic verify(input string tag, input int n, input int last, input int per);
    check({tag, "_count"}, wq.size() >= n, 1);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      int f, r;
      f = (i / 5) % (last + 1);
      r = i % 5;
      check($sformatf("%s_adr%0d", tag, i), wq[i].adr, r);
      check($sformatf("%s_dat%0d", tag, i), wq[i].dat, 32'(mdl_mem[f][r]));
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i), wq[i].rise - wq[i-1].rise - wq[i-1].len,
              (r == 0) ? per * DIV : 1);
    end
  endtask

  vec_t vt[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wbi.stb = 1'b0; wbi.we = 1'b0; wbi.adr = '0; wbi.dat_c = '0;
    repeat (3) @(negedge clk);
    check("rst_cp_stb", cpi.stb, 0);
    check("rst_cp_we", cpi.we, 0);
    check("rst_wb_ack", wbi.ack, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;

    vt[0]  = '{1'b0, 6'h20, 8'h00, 8'h00};
    vt[1]  = '{1'b0, 6'h21, 8'h00, 8'h01};
    vt[2]  = '{1'b0, 6'h22, 8'h00, 8'h00};
    vt[3]  = '{1'b0, 6'h23, 8'h00, 8'h00};
    vt[4]  = '{1'b0, 6'h3F, 8'h00, 8'h00};
    vt[5]  = '{1'b1, 6'h0A, 8'hFF, 8'h7F};
    vt[6]  = '{1'b1, 6'h05, 8'h55, 8'h00};
    vt[7]  = '{1'b1, 6'h21, 8'h00, 8'h00};
    vt[8]  = '{1'b1, 6'h21, 8'h02, 8'h02};
    vt[9]  = '{1'b1, 6'h20, 8'h0E, 8'h0E};
    vt[10] = '{1'b1, 6'h20, 8'h00, 8'h00};
    vt[11] = '{1'b1, 6'h1F, 8'h12, 8'h00};
    vt[12] = '{1'b1, 6'h1C, 8'h80, 8'h00};
    for (int i = 0; i < 13; i++) begin
      if (vt[i].wr) wb_write(vt[i].adr, vt[i].wdat);
      rd_check($sformatf("vec%0d", i), vt[i].adr, vt[i].exp);
    end

    // Two-frame single run, PERIOD=2.
    for (int r = 0; r < 5; r++) begin
      wb_write(6'(r), 8'(8'h01 + r));
      wb_write(6'(8 + r), 8'(8'h11 + r));
    end
    wb_write(6'h21, 8'd2);
    wq.delete();
    wb_write(6'h20, 8'h05);
    wait_writes(10, 500);
    repeat (2 * DIV + 10) @(negedge clk);
    verify("basic", 10, 1, 2);
    check("basic_n", wq.size(), 10);
    exp_irq += IRQ_ON;
    check("basic_irq", irq_cnt, exp_irq);
    rd_check("basic_status", 6'h22, 8'h06);
    rd_check("basic_ctrl", 6'h20, 8'h04);

    // Looping over frames 0,1 with PERIOD=1, then stopped.
    wb_write(6'h21, 8'd1);
    wq.delete();
    wb_write(6'h20, 8'h07);
    wait_writes(20, 1000);
    verify("loop", 20, 1, 1);
    begin
      logic [7:0] s;
      @(negedge clk); wbi.stb = 1'b1; wbi.we = 1'b0; wbi.adr = 6'h22;
      @(negedge clk); wbi.stb = 1'b0; s = wbi.dat_p;
      check("loop_busy", s[0], 1);
      check("loop_done", s[1], 0);
    end
    check("loop_irq", irq_cnt, exp_irq);
    wb_write(6'h20, 8'h00);
    repeat (40) @(negedge clk);
    check("loop_whole_frames", wq.size() % 5, 0);
    begin
      logic [7:0] s;
      @(negedge clk); wbi.stb = 1'b1; wbi.we = 1'b0; wbi.adr = 6'h22;
      @(negedge clk); wbi.stb = 1'b0; s = wbi.dat_p;
      check("loop_stopped", s[1:0], 0);
    end
    check("loop_irq_after", irq_cnt, exp_irq);

    // Row 2 ack held off 4 cycles.
    slow_row = 2;
    wq.delete();
    wb_write(6'h20, 8'h01);
    wait_writes(5, 300);
    repeat (DIV + 10) @(negedge clk);
    verify("slow", 5, 0, 1);
    check("slow_n", wq.size(), 5);
    for (int i = 0; i < 5 && i < wq.size(); i++)
      check($sformatf("slow_len%0d", i), wq[i].len, (i == 2) ? 5 : 2);
    check("slow_gap_err", gap_err, 0);
    exp_irq += IRQ_ON;
    rd_check("slow_status", 6'h22, 8'h02);
    slow_row = -1;

    // EN=0 written during row-1 strobe: frame completes, no DONE.
    wq.delete();
    wb_write(6'h20, 8'h05);
    wait_stb_row(1, 100);
    wb_write(6'h20, 8'h00);
    repeat (40) @(negedge clk);
    verify("stop", 5, 1, 1);
    check("stop_n", wq.size(), 5);
    rd_check("stop_status", 6'h22, 8'h00);
    rd_check("stop_ctrl", 6'h20, 8'h00);

    // Reset in the middle of a frame load.
    wb_write(6'h21, 8'd3);
    wq.delete();
    wb_write(6'h20, 8'h05);
    wait_stb_row(2, 100);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stb", cpi.stb, 0);
    check("mid_rst_ack", wbi.ack, 0);
    check("mid_rst_irq", irq, 0);
    rst = 1'b0;
    rd_check("mid_rst_status", 6'h22, 8'h00);
    rd_check("mid_rst_period", 6'h21, 8'h01);
    rd_check("mid_rst_ctrl", 6'h20, 8'h00);
    rd_check("mid_rst_mem", 6'h09, {1'b0, mdl_mem[1][1]});
    check("mid_rst_irq_cnt", irq_cnt, exp_irq);

    // Randomized runs: random frame data, PERIOD, LAST and ack latency.
    rand_ack = 1;
    for (int run = 0; run < 4; run++) begin
      int per, eff, last, n;
      for (int a = 0; a < 32; a++) wb_write(6'(a), 8'($urandom));
      per  = $urandom_range(0, 3);
      eff  = (per == 0) ? 1 : per;
      last = $urandom_range(0, 3);
      n    = 5 * (last + 1);
      wb_write(6'h21, 8'(per));
      wq.delete();
      wb_write(6'h20, 8'(last * 4 + 1));
      wait_writes(n, 3000);
      repeat (eff * DIV + 10) @(negedge clk);
      verify($sformatf("rnd%0d", run), n, last, eff);
      check($sformatf("rnd%0d_n", run), wq.size(), n);
      exp_irq += IRQ_ON;
      rd_check($sformatf("rnd%0d_status", run), 6'h22, 8'(last * 4 + 2));
      rd_check($sformatf("rnd%0d_ctrl", run), 6'h20, 8'(last * 4));
    end
    rand_ack = 0;

    check("gap_err_total", gap_err, 0);
    check("irq_total", irq_cnt, exp_irq);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
